gfx_mem_arbiter: RTL and testbench
==================================

Name: gfx_mem_arbiter

Overview:
- Upstream memory server for the gfx block's four read-only pixel-fetch ports: sprite controller, BG0, BG1 and overlay.
- Arbitrates those ports round-robin onto one pipelined read port of the shared video memory.
- Issues at most one read per cycle and routes each returning word back to the port that requested it.
- Uses each port's rvalid/rready handshake unchanged, so gfx connects directly.

Parameters:
- MEM_LATENCY, 1, memory read latency in cycles; data is valid in cycle N+MEM_LATENCY for an issue in cycle N; legal range 1..3.
- ADDR_BITS, 16, width of every address bus.
- DATA_BITS, 16, width of every data bus.

Ports:
- CLK  in  1  system clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- spcon_memory_address  in  ADDR_BITS  sprite fetch address; held while spcon_rvalid=1.
- spcon_rvalid  in  1  sprite read request.
- spcon_memory_data  out  DATA_BITS  sprite read data; valid when spcon_rready=1.
- spcon_rready  out  1  one-cycle completion pulse for the sprite port.
- bg0_memory_address, bg0_rvalid, bg0_memory_data, bg0_rready: same as the sprite port, for BG0.
- bg1_memory_address, bg1_rvalid, bg1_memory_data, bg1_rready: same, for BG1.
- ov_memory_address, ov_rvalid, ov_memory_data, ov_rready: same, for the overlay.
- mem_address  out  ADDR_BITS  address to video memory; 0 when mem_rd=0.
- mem_rd  out  1  read strobe, valid in the issue cycle.
- mem_gnt  in  1  memory available this cycle; 0 while the CPU owns the memory.
- mem_data  in  DATA_BITS  read data, valid MEM_LATENCY cycles after the issue.

Behaviour:
- Port index: 0=spcon, 1=bg0, 2=bg1, 3=ov.
- Eligibility: port p is eligible when rvalid_p=1 and busy_p=0.
- Issue, cycle N:
  - Condition: mem_gnt=1 and at least one port eligible.
  - Winner: first eligible port scanning from ptr upward, mod 4.
  - mem_rd=1 and mem_address=address of the winner; both are combinational in cycle N.
  - At the end-of-N edge: busy_p<=1 and ptr<=(p+1) mod 4; a tag (valid, p) enters the return pipeline, which is MEM_LATENCY deep.
- No issue: if mem_gnt=0 or nothing is eligible, then mem_rd=0, mem_address=0, and ptr is unchanged.
- mem_gnt gates issue only. In-flight returns always complete.
- Return:
  - At the edge ending cycle N+MEM_LATENCY: data_p<=mem_data and rready_p<=1.
  - rready_p is high for exactly cycle N+MEM_LATENCY+1.
  - data_p holds its value until that port's next return.
- Busy release: busy_p clears at the edge ending cycle N+MEM_LATENCY+1. The port is eligible again from cycle N+MEM_LATENCY+2, which lets the requester present a new address after sampling rready.
- Per-port throughput: one request per MEM_LATENCY+2 cycles.
- Aggregate throughput: one issue per cycle.
- At most one rready is high in any cycle.
- rvalid_p dropped while busy_p=1: the response is still delivered (rready pulse, data updated). Requesters ignore it.
- Address changed while rvalid_p=1 and not yet granted: the arbiter uses the address present in the issue cycle.
- Reset: when RST=1 at an edge, every rready, data, busy, ptr and tag bit is cleared to 0.
  - While RST=1: mem_rd=0 and mem_address=0.
  - Reads already in flight are discarded and never produce rready.
  - The first issue is possible in the first cycle with RST=0.
- Arithmetic: ptr is 2 bits and wraps naturally. There is no other arithmetic.

Decomposition:
- Package gfx_mem_pkg: port-index constants (PORT_SPCON=0, PORT_BG0=1, PORT_BG1=2, PORT_OV=3), NUM_PORTS=4, and the return-tag record (valid, 2-bit index).
- Sub-module rr_arbiter4: combinational 4-way round-robin pick.
  - Inputs: 4-bit request vector, 2-bit ptr.
  - Outputs: grant_valid, 2-bit grant index.
- The top level holds ptr, the busy bits, the tag pipeline and the per-port data/rready registers.

Test Plan (MEM_LATENCY=1 unless stated):
- Reset: RST=1 for 3 cycles with all rvalid=1 -> mem_rd=0, mem_address=0, all rready=0, all data=0; the first issue (spcon, ptr=0) happens in the first cycle after RST falls.
- Single read: bg0 requests address 0x1234 in cycle N; memory returns 0xBEEF in N+1 -> mem_address=0x1234 and mem_rd=1 in N; bg0_rready=1 only in N+2 with bg0_memory_data=0xBEEF; bg0 is not reissued in N+1 or N+2.
- Saturation: all four ports hold rvalid and present a new address right after each rready -> mem_rd=1 every cycle; grant order spcon, bg0, bg1, ov repeating; each port completes once every 4 cycles.
- Stall: mem_gnt=0 for 5 cycles while spcon and ov request, one bg1 read in flight -> no issue during the stall; bg1_rready still pulses on time; on release spcon issues first, then ov.
- Fairness: after an ov grant (ptr=0), bg0 and ov request together with spcon idle -> bg0 is granted, then ov the following cycle.
- Reset mid-flight, MEM_LATENCY=3: bg1 issued in cycle N, RST=1 in cycle N+1 -> bg1_rready never asserts and busy is cleared.

Source files
------------

// File: rtl/gfx_mem_pkg.sv
// Shared types for the gfx memory arbiter: port indices and the return-tag record.
package gfx_mem_pkg;

    localparam int unsigned NUM_PORTS     = 4;
    localparam int unsigned PORT_IDX_BITS = 2;

    typedef logic [PORT_IDX_BITS-1:0] port_idx_t;

    localparam port_idx_t PORT_SPCON = 2'd0;
    localparam port_idx_t PORT_BG0   = 2'd1;
    localparam port_idx_t PORT_BG1   = 2'd2;
    localparam port_idx_t PORT_OV    = 2'd3;

    // One entry of the read-return pipeline: which port owns the word arriving from memory.
    typedef struct packed {
        logic      valid;
        port_idx_t idx;
    } ret_tag_t;

endpackage

// File: rtl/gfx_mem_arbiter_if.sv
// Bundle of the four pixel-fetch ports plus the shared video-memory read port.
interface gfx_mem_arbiter_if #(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned DATA_BITS = 16
);
    logic [ADDR_BITS-1:0] spcon_memory_address;
    logic                 spcon_rvalid;
    logic [DATA_BITS-1:0] spcon_memory_data;
    logic                 spcon_rready;

    logic [ADDR_BITS-1:0] bg0_memory_address;
    logic                 bg0_rvalid;
    logic [DATA_BITS-1:0] bg0_memory_data;
    logic                 bg0_rready;

    logic [ADDR_BITS-1:0] bg1_memory_address;
    logic                 bg1_rvalid;
    logic [DATA_BITS-1:0] bg1_memory_data;
    logic                 bg1_rready;

    logic [ADDR_BITS-1:0] ov_memory_address;
    logic                 ov_rvalid;
    logic [DATA_BITS-1:0] ov_memory_data;
    logic                 ov_rready;

    logic [ADDR_BITS-1:0] mem_address;
    logic                 mem_rd;
    logic                 mem_gnt;
    logic [DATA_BITS-1:0] mem_data;

    // Arbiter side: serves the fetch ports and drives the memory read port.
    modport slave (
        input  spcon_memory_address, spcon_rvalid,
        output spcon_memory_data, spcon_rready,
        input  bg0_memory_address, bg0_rvalid,
        output bg0_memory_data, bg0_rready,
        input  bg1_memory_address, bg1_rvalid,
        output bg1_memory_data, bg1_rready,
        input  ov_memory_address, ov_rvalid,
        output ov_memory_data, ov_rready,
        output mem_address, mem_rd,
        input  mem_gnt, mem_data
    );

    // Requester / memory side.
    modport master (
        output spcon_memory_address, spcon_rvalid,
        input  spcon_memory_data, spcon_rready,
        output bg0_memory_address, bg0_rvalid,
        input  bg0_memory_data, bg0_rready,
        output bg1_memory_address, bg1_rvalid,
        input  bg1_memory_data, bg1_rready,
        output ov_memory_address, ov_rvalid,
        input  ov_memory_data, ov_rready,
        input  mem_address, mem_rd,
        output mem_gnt, mem_data
    );

endinterface

// File: rtl/gfx_mem_arbiter_rr.sv
// Combinational 4-way round-robin pick: first requester at or above ptr, wrapping.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       grant_valid,
    output logic [1:0] grant_idx
);

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!grant_valid && req[ptr + 2'(i)]) begin
                grant_valid = 1'b1;
                grant_idx   = ptr + 2'(i);
            end
        end
    end

endmodule

// File: rtl/gfx_mem_arbiter.sv
// Round-robin read server for the four gfx fetch ports onto one pipelined video-memory port.
module gfx_mem_arbiter
    import gfx_mem_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned ADDR_BITS   = 16,
    parameter int unsigned DATA_BITS   = 16
) (
    input  logic              CLK,
    input  logic              RST,
    gfx_mem_arbiter_if.slave  bus
);

    logic [NUM_PORTS-1:0] rvalid;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] busy_q;
    logic [NUM_PORTS-1:0] rready_q;
    logic [NUM_PORTS-1:0] issue_onehot;
    logic [ADDR_BITS-1:0] addr   [NUM_PORTS];
    logic [DATA_BITS-1:0] data_q [NUM_PORTS];
    ret_tag_t             tag_q  [MEM_LATENCY];
    ret_tag_t             ret;
    port_idx_t            ptr_q;
    port_idx_t            grant_idx;
    logic                 grant_valid;
    logic                 issue;

    assign rvalid = {bus.ov_rvalid, bus.bg1_rvalid, bus.bg0_rvalid, bus.spcon_rvalid};

    assign addr[PORT_SPCON] = bus.spcon_memory_address;
    assign addr[PORT_BG0]   = bus.bg0_memory_address;
    assign addr[PORT_BG1]   = bus.bg1_memory_address;
    assign addr[PORT_OV]    = bus.ov_memory_address;

    // A port may not re-request until its previous word has been handed back.
    assign eligible = rvalid & ~busy_q;

    rr_arbiter4 u_rr (
        .req         (eligible),
        .ptr         (ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        issue        = 1'b0;
        issue_onehot = '0;
        if (bus.mem_gnt && grant_valid && !RST) begin
            issue        = 1'b1;
            issue_onehot = NUM_PORTS'(1) << grant_idx;
        end
    end

    assign bus.mem_rd      = issue;
    assign bus.mem_address = issue ? addr[grant_idx] : '0;

    // Tag leaving the pipeline matches the word currently on mem_data.
    assign ret = tag_q[MEM_LATENCY-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q    <= '0;
            busy_q   <= '0;
            rready_q <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                data_q[p] <= '0;
            end
            for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            if (issue) begin
                ptr_q <= grant_idx + 2'd1;
            end
            tag_q[0].valid <= issue;
            tag_q[0].idx   <= issue ? grant_idx : '0;
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            rready_q <= '0;
            if (ret.valid) begin
                rready_q[ret.idx] <= 1'b1;
                data_q[ret.idx]   <= bus.mem_data;
            end
            // Busy drops on the edge ending the rready cycle.
            busy_q <= (busy_q & ~rready_q) | issue_onehot;
        end
    end

    assign bus.spcon_memory_data = data_q[PORT_SPCON];
    assign bus.bg0_memory_data   = data_q[PORT_BG0];
    assign bus.bg1_memory_data   = data_q[PORT_BG1];
    assign bus.ov_memory_data    = data_q[PORT_OV];

    assign bus.spcon_rready = rready_q[PORT_SPCON];
    assign bus.bg0_rready   = rready_q[PORT_BG0];
    assign bus.bg1_rready   = rready_q[PORT_BG1];
    assign bus.ov_rready    = rready_q[PORT_OV];

endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// Directed bench for gfx_mem_arbiter: vector table at MEM_LATENCY=1 plus hand sequences.
module tb_gfx_mem_arbiter;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_vec;
    int   n_miss;

    always #5 clk = ~clk;

    gfx_mem_arbiter_if #(.ADDR_BITS(16), .DATA_BITS(16)) ifa ();
    gfx_mem_arbiter_if #(.ADDR_BITS(16), .DATA_BITS(16)) ifb ();

    gfx_mem_arbiter #(.MEM_LATENCY(1), .ADDR_BITS(16), .DATA_BITS(16)) dut_a (
        .CLK (clk),
        .RST (rst_a),
        .bus (ifa)
    );

    gfx_mem_arbiter #(.MEM_LATENCY(3), .ADDR_BITS(16), .DATA_BITS(16)) dut_b (
        .CLK (clk),
        .RST (rst_b),
        .bus (ifb)
    );

    // Memory models: word = address + 0xACBB, returned MEM_LATENCY cycles after issue.
    logic [15:0] mem_a_q;
    logic [15:0] mem_b_q [3];

    always @(posedge clk) begin
        mem_a_q    <= ifa.mem_rd ? ifa.mem_address + 16'hACBB : 16'hDEAD;
        mem_b_q[0] <= ifb.mem_rd ? ifb.mem_address + 16'hACBB : 16'hDEAD;
        mem_b_q[1] <= mem_b_q[0];
        mem_b_q[2] <= mem_b_q[1];
    end

    assign ifa.mem_data = mem_a_q;
    assign ifb.mem_data = mem_b_q[2];

    typedef struct {
        logic       rst;
        logic       gnt;
        logic [3:0] rv;
        logic       rd;
        int         port;
        logic [3:0] rdy;
    } vec_t;

    vec_t        vq [$];
    logic [15:0] paddr [4];
    logic [15:0] held  [4];
    int          cnt   [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic g, input logic [3:0] rv);
        ifa.mem_gnt      = g;
        ifa.spcon_rvalid = rv[0];
        ifa.bg0_rvalid   = rv[1];
        ifa.bg1_rvalid   = rv[2];
        ifa.ov_rvalid    = rv[3];
    endtask

    task automatic addr_a(input logic [15:0] a0, input logic [15:0] a1,
                          input logic [15:0] a2, input logic [15:0] a3);
        ifa.spcon_memory_address = a0;
        ifa.bg0_memory_address   = a1;
        ifa.bg1_memory_address   = a2;
        ifa.ov_memory_address    = a3;
    endtask

    function automatic logic [3:0] rdy_a();
        return {ifa.ov_rready, ifa.bg1_rready, ifa.bg0_rready, ifa.spcon_rready};
    endfunction

    function automatic logic [3:0] rdy_b();
        return {ifb.ov_rready, ifb.bg1_rready, ifb.bg0_rready, ifb.spcon_rready};
    endfunction

    function automatic logic [15:0] data_a(input int p);
        case (p)
            0:       return ifa.spcon_memory_data;
            1:       return ifa.bg0_memory_data;
            2:       return ifa.bg1_memory_data;
            default: return ifa.ov_memory_data;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic g, input logic [3:0] rv,
                       input logic rd, input int port, input logic [3:0] rdy);
        vec_t v;
        v.rst = r; v.gnt = g; v.rv = rv; v.rd = rd; v.port = port; v.rdy = rdy;
        vq.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec  = 0;
        n_miss = 0;
        paddr  = '{16'h0A00, 16'h1234, 16'h3300, 16'h4400};
        held   = '{16'h0, 16'h0, 16'h0, 16'h0};

        // rst gnt rv rd port rdy : reset, single read, rvalid drop, fairness, stall
        for (int i = 0; i < 3; i++) add(1, 1, 4'b1111, 0, 0, 4'b0000);
        add(0, 1, 4'b1111, 1, 0, 4'b0000);
        add(0, 1, 4'b0000, 0, 0, 4'b0000);
        add(0, 1, 4'b0010, 1, 1, 4'b0001);
        add(0, 1, 4'b0010, 0, 0, 4'b0000);
        add(0, 1, 4'b0010, 0, 0, 4'b0010);
        add(0, 1, 4'b0000, 0, 0, 4'b0000);
        add(0, 1, 4'b1000, 1, 3, 4'b0000);
        add(0, 1, 4'b0000, 0, 0, 4'b0000);
        add(0, 1, 4'b0000, 0, 0, 4'b1000);
        add(0, 1, 4'b1010, 1, 1, 4'b0000);
        add(0, 1, 4'b1010, 1, 3, 4'b0000);
        add(0, 1, 4'b0000, 0, 0, 4'b0010);
        add(0, 1, 4'b0000, 0, 0, 4'b1000);
        add(0, 1, 4'b0100, 1, 2, 4'b0000);
        add(0, 1, 4'b1000, 1, 3, 4'b0000);
        add(0, 0, 4'b1001, 0, 0, 4'b0100);
        add(0, 0, 4'b1001, 0, 0, 4'b1000);
        for (int i = 0; i < 3; i++) add(0, 0, 4'b1001, 0, 0, 4'b0000);
        add(0, 1, 4'b1001, 1, 0, 4'b0000);
        add(0, 1, 4'b1001, 1, 3, 4'b0000);
        add(0, 1, 4'b0000, 0, 0, 4'b0001);
        add(0, 1, 4'b0000, 0, 0, 4'b1000);

        rst_a = 1'b1;
        rst_b = 1'b1;
        drive_a(1'b1, 4'b1111);
        addr_a(paddr[0], paddr[1], paddr[2], paddr[3]);
        ifb.mem_gnt = 1'b1;
        ifb.spcon_rvalid = 1'b0; ifb.bg0_rvalid = 1'b0;
        ifb.bg1_rvalid   = 1'b0; ifb.ov_rvalid  = 1'b0;
        ifb.spcon_memory_address = 16'h0; ifb.bg0_memory_address = 16'h0;
        ifb.bg1_memory_address   = 16'h0; ifb.ov_memory_address  = 16'h0;
        tick();

        foreach (vq[i]) begin
            rst_a = vq[i].rst;
            drive_a(vq[i].gnt, vq[i].rv);
            @(negedge clk);
            for (int p = 0; p < 4; p++)
                if (vq[i].rdy[p]) held[p] = paddr[p] + 16'hACBB;
            check($sformatf("row%0d mem_rd", i), 32'(ifa.mem_rd), 32'(vq[i].rd));
            check($sformatf("row%0d mem_address", i), 32'(ifa.mem_address),
                  32'(vq[i].rd ? paddr[vq[i].port] : 16'h0));
            check($sformatf("row%0d rready", i), 32'(rdy_a()), 32'(vq[i].rdy));
            for (int p = 0; p < 4; p++)
                check($sformatf("row%0d data%0d", i, p), 32'(data_a(p)), 32'(held[p]));
            tick();
        end

        // Saturation: every port always requesting, new address after each rready.
        cnt = '{0, 0, 0, 0};
        drive_a(1'b1, 4'b1111);
        for (int k = 0; k < 16; k++) begin
            addr_a(16'h5000 + 16'(cnt[0]), 16'h5100 + 16'(cnt[1]),
                   16'h5200 + 16'(cnt[2]), 16'h5300 + 16'(cnt[3]));
            @(negedge clk);
            check($sformatf("sat%0d mem_rd", k), 32'(ifa.mem_rd), 32'd1);
            check($sformatf("sat%0d mem_address", k), 32'(ifa.mem_address),
                  32'(16'h5000 + 16'((k % 4) << 8) + 16'(k / 4)));
            if (k >= 2) begin
                check($sformatf("sat%0d rready", k), 32'(rdy_a()), 32'(4'b0001 << ((k - 2) % 4)));
                check($sformatf("sat%0d data", k), 32'(data_a((k - 2) % 4)),
                      32'(16'h5000 + 16'(((k - 2) % 4) << 8) + 16'((k - 2) / 4) + 16'hACBB));
            end else begin
                check($sformatf("sat%0d rready", k), 32'(rdy_a()), 32'd0);
            end
            for (int p = 0; p < 4; p++)
                if (rdy_a()[p]) cnt[p]++;
            tick();
        end
        drive_a(1'b1, 4'b0000);
        for (int k = 0; k < 4; k++) tick();

        // Address changes while waiting for grant: the issue-cycle address wins.
        drive_a(1'b0, 4'b0100);
        addr_a(16'h0, 16'h0, 16'h7777, 16'h0);
        @(negedge clk);
        check("chg stall mem_rd", 32'(ifa.mem_rd), 32'd0);
        check("chg stall mem_address", 32'(ifa.mem_address), 32'd0);
        tick();
        addr_a(16'h0, 16'h0, 16'h7778, 16'h0);
        tick();
        ifa.mem_gnt = 1'b1;
        @(negedge clk);
        check("chg issue mem_rd", 32'(ifa.mem_rd), 32'd1);
        check("chg issue mem_address", 32'(ifa.mem_address), 32'h7778);
        tick();
        tick();
        @(negedge clk);
        check("chg rready", 32'(rdy_a()), 32'b0100);
        check("chg data", 32'(ifa.bg1_memory_data), 32'h2433);
        tick();
        drive_a(1'b1, 4'b0000);

        // MEM_LATENCY=3: reset one cycle after issue discards the read and frees the port.
        @(negedge clk);
        check("lat3 in reset mem_rd", 32'(ifb.mem_rd), 32'd0);
        tick();
        rst_b = 1'b0;
        ifb.bg1_rvalid = 1'b1;
        ifb.bg1_memory_address = 16'h2468;
        @(negedge clk);
        check("lat3 N mem_rd", 32'(ifb.mem_rd), 32'd1);
        check("lat3 N mem_address", 32'(ifb.mem_address), 32'h2468);
        tick();
        rst_b = 1'b1;
        @(negedge clk);
        check("lat3 N+1 mem_rd", 32'(ifb.mem_rd), 32'd0);
        check("lat3 N+1 mem_address", 32'(ifb.mem_address), 32'd0);
        tick();
        rst_b = 1'b0;
        ifb.bg1_memory_address = 16'h1357;
        @(negedge clk);
        check("lat3 N+2 reissue mem_rd", 32'(ifb.mem_rd), 32'd1);
        check("lat3 N+2 mem_address", 32'(ifb.mem_address), 32'h1357);
        tick();
        ifb.bg1_rvalid = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("lat3 N+%0d rready", k), 32'(rdy_b()), 32'd0);
            check($sformatf("lat3 N+%0d data", k), 32'(ifb.bg1_memory_data), 32'd0);
            tick();
        end
        @(negedge clk);
        check("lat3 N+6 rready", 32'(rdy_b()), 32'b0100);
        check("lat3 N+6 data", 32'(ifb.bg1_memory_data), 32'hC012);
        tick();
        @(negedge clk);
        check("lat3 N+7 rready", 32'(rdy_b()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
